gp0_cmd_fifo: RTL and testbench
===============================

# gp0_cmd_fifo

GP0 command FIFO sitting directly upstream of the GPU. It accepts 32-bit GP0 writes from the CPU/DMA bus, buffers them, and decodes packet boundaries on the write side. It tags every stored word with start/end/terminator flags, so the GPU front end pops complete units without re-parsing lengths. It also produces the GP0-related GPUSTAT ready bits.

## Interface
- DEPTH, 16: FIFO entries; power of two, at least 4.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wr_data  in  32  GP0 word from main_bus
- wr_en  in  1  GP0 write strobe (to_gp0)
- flush  in  1  GP1 reset / reset-command-buffer; one-cycle pulse
- rd_ready  in  1  GPU pops head word
- rd_data  out  32  head word
- rd_sop / rd_eop / rd_term  out  1 each  head tags: packet start, unit end, polyline terminator
- rd_valid  out  1  head valid (FIFO not empty)
- cmd_avail  out  1  at least one complete unit (eop-tagged word) stored
- level  out  $clog2(DEPTH)+1  occupancy
- full, empty  out  1  occupancy flags
- overflow  out  1  sticky: a write arrived while full
- rdy_cmd  out  1  GPUSTAT bit 26, equal to empty
- rdy_dma  out  1  GPUSTAT bit 28, equal to !full

## Operation
- Write is accepted iff wr_en & !full. A write while full drops the word, sets overflow, and leaves the decoder unchanged.
- A pop occurs iff rd_valid & rd_ready. Simultaneous accepted write and pop keep level unchanged.
- unit_cnt increments on an accepted eop-tagged write and decrements on an eop-tagged pop; both in the same cycle leave it unchanged. cmd_avail = (unit_cnt != 0).
- Decoder states: IDLE, FIXED, POLY_FIRST, POLY_SEG, IMG_HDR, IMG_DATA. It advances only on accepted writes.
- IDLE: the word is a header and is tagged sop. Its opcode is op = wr_data[31:24], and len is the packet length in words.
  - 0x02 → 3.
  - 0x20–0x3F polygon: v = bit27 ? 4 : 3, t = bit26, g = bit28; len = v*(1+t+g) + (g ? 0 : 1).
  - 0x40–0x5F line: bit27 = 0 → len 3+g. bit27 = 1 → POLY_FIRST with 2+2g words remaining.
  - 0x60–0x7F rect: len = 2 + bit26 + (bits28:27 == 0).
  - 0x80–0x9F → 4. 0xA0–0xBF → IMG_HDR, 2 remaining. 0xC0–0xDF → 3.
  - All other opcodes → 1.
  - If len = 1, the header is also tagged eop and the state stays IDLE. Otherwise go to FIXED with len-1 remaining.
- FIXED: decrement remaining. The last word is tagged eop, then return to IDLE.
- POLY_FIRST: as FIXED, but on the last word go to POLY_SEG instead of IDLE.
- POLY_SEG: each vertex group is 1+g words.
  - On a group's first word, if (w & 0xF000F000) == 0x50005000, tag the word eop+term and return to IDLE.
  - Otherwise the group's last word is tagged eop.
- IMG_HDR: word 2 (x/y) passes through. Word 3 (w/h) is tagged eop.
  - The decoder computes W = ((w[9:0]-1) & 0x3FF)+1 and H = ((h[24:16]-1) & 0x1FF)+1, then words = (W*H+1) >> 1, using a 19-bit counter.
  - Then go to IMG_DATA.
- IMG_DATA: every payload word is tagged eop only (sop=0) and the counter decrements. At 0, return to IDLE.
- flush or rst: clear pointers, level, unit_cnt, and overflow; decoder goes to IDLE. A write in the same cycle as flush is discarded.

## Timing
- Reset values: rd_valid 0, rd_data 0, all tags 0, cmd_avail 0, level 0, empty 1, full 0, overflow 0, rdy_cmd 1, rdy_dma 1.
- There is no write-to-read bypass. A word written at edge N is visible at the head after edge N, so rd_valid rises one cycle after the write.
- rd_data and the tags are the stored head entry and change only after a pop, write-into-empty, or flush.
- All flags are derived from registered level/unit_cnt. full is not relieved by a same-cycle pop, so a write when full is dropped even if rd_ready is high.
- Pointers wrap modulo DEPTH. level uses an extra bit to distinguish full from empty.
- Throughput is one write and one pop per cycle sustained.

## Structure
- gpu_pkg holds the following; gp0_cmd_fifo imports gpu_pkg.
  - gp0_tag_t (sop, eop, term packed struct).
  - The gp0_dec_state_t enum.
  - The function gp0_pkt_len(op) returning length/kind.
  - The constant GP0_POLY_TERM = 32'h5000_5000 with its mask.
- Sub-module gp0_pkt_decode holds the decoder FSM and counters. It receives the accepted write and outputs the tags.
- The storage is a DEPTH × 35-bit register array inside gp0_cmd_fifo.

## Test plan
- Write 0x2000_00FF, then 3 vertex words → 4 words stored: sop on word 1, eop on word 4. cmd_avail rises the cycle after word 4. level = 4.
- Write 0x3C00_0000 → 12-word packet; eop only on word 12. Then write 0xE100_0000 → a single word tagged sop+eop.
- Polyline 0x4800_0000, v0, v1, v2, 0x5555_5555 → word 3 has eop. v2 has eop. The terminator has eop+term. The decoder returns to IDLE, and the next header is tagged sop.
- Write 0xA000_0000, 0, then 0x0002_0003 (W=3, H=2) → 3 payload words, each eop-only. The next word is treated as a header.
- Write 17 words with rd_ready=0 → full = 1 after 16. The 17th write is dropped, overflow = 1, rdy_dma = 0. A pop does not clear overflow.
- flush mid-packet (after word 2 of a 0x80 copy) → next cycle: level 0, empty 1, cmd_avail 0, overflow 0. A following 0x0000_0000 is tagged sop+eop.

Source files
------------

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared GP0 tag/decoder types, packet-length lookup and polyline terminator constants.
package gpu_pkg;
  typedef struct packed {
    logic sop;
    logic eop;
    logic term;
  } gp0_tag_t;
  typedef enum logic [2:0] {IDLE, FIXED, POLY_FIRST, POLY_SEG, IMG_HDR, IMG_DATA} gp0_dec_state_t;
  typedef enum logic [1:0] {K_FIXED, K_POLY, K_IMG} gp0_kind_t;
  typedef struct packed {
    gp0_kind_t  kind;
    logic [3:0] len;
  } gp0_pkt_t;
  localparam logic [31:0] GP0_POLY_TERM = 32'h5000_5000;
  localparam logic [31:0] GP0_POLY_MASK = 32'hF000_F000;
  // len counts the header; polyline len covers only the first fixed part.
  function automatic gp0_pkt_t gp0_pkt_len(input logic [7:0] op);
    gp0_pkt_t p;
    logic [3:0] v;
    v = op[3] ? 4'd4 : 4'd3;
    p.kind = K_FIXED;
    p.len = 4'd1;
    case (op[7:5])
      3'd0: p.len = (op == 8'h02) ? 4'd3 : 4'd1;
      3'd1: p.len = v * (4'd1 + {3'b0, op[2]} + {3'b0, op[4]}) + {3'b0, ~op[4]};
      3'd2: begin
        p.kind = op[3] ? K_POLY : K_FIXED;
        p.len = op[3] ? 4'd3 + {2'b0, op[4], 1'b0} : 4'd3 + {3'b0, op[4]};
      end
      3'd3: p.len = 4'd2 + {3'b0, op[2]} + {3'b0, op[4:3] == 2'b00};
      3'd4: p.len = 4'd4;
      3'd5: begin
        p.kind = K_IMG;
        p.len = 4'd3;
      end
      3'd6: p.len = 4'd3;
      default: p.len = 4'd1;
    endcase
    return p;
  endfunction
endpackage

// File: rtl/gp0_cmd_fifo_if.sv
// gp0_cmd_fifo_if: GP0 write port, GPU pop port and status flags of the command FIFO.
interface gp0_cmd_fifo_if #(parameter int DEPTH = 16);
  localparam int LW = $clog2(DEPTH) + 1;
  logic [31:0]   wr_data;
  logic          wr_en;
  logic          flush;
  logic          rd_ready;
  logic [31:0]   rd_data;
  logic          rd_sop;
  logic          rd_eop;
  logic          rd_term;
  logic          rd_valid;
  logic          cmd_avail;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          rdy_cmd;
  logic          rdy_dma;
  modport master (
    output wr_data, wr_en, flush, rd_ready,
    input  rd_data, rd_sop, rd_eop, rd_term, rd_valid, cmd_avail, level, full, empty, overflow, rdy_cmd, rdy_dma
  );
  modport slave (
    input  wr_data, wr_en, flush, rd_ready,
    output rd_data, rd_sop, rd_eop, rd_term, rd_valid, cmd_avail, level, full, empty, overflow, rdy_cmd, rdy_dma
  );
endinterface

// File: rtl/gp0_pkt_decode.sv
// gp0_pkt_decode: write-side GP0 packet boundary decoder producing sop/eop/term tags per accepted word.
module gp0_pkt_decode
  import gpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        wr_i,
  input  logic [31:0] data_i,
  output gp0_tag_t    tag_o
);
  gp0_dec_state_t state_q, state_d;
  logic [3:0]  rem_q, rem_d;
  logic [18:0] img_q, img_d;
  logic        g_q, g_d, pos_q, pos_d;
  gp0_pkt_t    pkt;
  logic [10:0] img_w;
  logic [9:0]  img_h;
  assign pkt = gp0_pkt_len(data_i[31:24]);
  assign img_w = {1'b0, data_i[9:0] - 10'd1} + 11'd1;
  assign img_h = {1'b0, data_i[24:16] - 9'd1} + 10'd1;
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    img_d = img_q;
    g_d = g_q;
    pos_d = pos_q;
    tag_o = '0;
    if (wr_i) begin
      case (state_q)
        IDLE: begin
          tag_o.sop = 1'b1;
          tag_o.eop = pkt.len == 4'd1;
          g_d = data_i[28];
          pos_d = 1'b0;
          rem_d = pkt.len - 4'd1;
          if (pkt.len != 4'd1)
            state_d = pkt.kind == K_POLY ? POLY_FIRST : pkt.kind == K_IMG ? IMG_HDR : FIXED;
        end
        FIXED, POLY_FIRST: begin
          rem_d = rem_q - 4'd1;
          tag_o.eop = rem_q == 4'd1;
          if (rem_q == 4'd1) state_d = state_q == FIXED ? IDLE : POLY_SEG;
        end
        POLY_SEG: begin
          // Terminator is only recognised on the first word of a vertex group.
          if (!pos_q && (data_i & GP0_POLY_MASK) == GP0_POLY_TERM) begin
            tag_o.eop = 1'b1;
            tag_o.term = 1'b1;
            state_d = IDLE;
          end else begin
            tag_o.eop = pos_q == g_q;
            pos_d = pos_q != g_q;
          end
        end
        IMG_HDR: begin
          rem_d = rem_q - 4'd1;
          tag_o.eop = rem_q == 4'd1;
          if (rem_q == 4'd1) begin
            img_d = 19'((21'(img_w) * 21'(img_h) + 21'd1) >> 1);
            state_d = IMG_DATA;
          end
        end
        IMG_DATA: begin
          tag_o.eop = 1'b1;
          img_d = img_q - 19'd1;
          if (img_q == 19'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      state_q <= IDLE;
      rem_q <= '0;
      img_q <= '0;
      g_q <= 1'b0;
      pos_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      img_q <= img_d;
      g_q <= g_d;
      pos_q <= pos_d;
    end
  end
endmodule

// File: rtl/gp0_cmd_fifo.sv
// gp0_cmd_fifo: GP0 command FIFO storing decoder-tagged words and producing GPUSTAT ready bits.
module gp0_cmd_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  gp0_cmd_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [34:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, unit_q;
  logic          ovf_q;
  logic          full, empty, wr_ok, pop;
  gp0_tag_t      wtag, htag;
  logic [34:0]   head;
  assign full = level_q == LW'(DEPTH);
  assign empty = level_q == '0;
  assign wr_ok = bus.wr_en && !full && !bus.flush;
  assign pop = !empty && bus.rd_ready && !bus.flush;
  assign head = mem_q[rd_ptr_q];
  assign htag = head[34:32];
  gp0_pkt_decode u_dec (
    .clk     (clk),
    .rst     (rst),
    .flush_i (bus.flush),
    .wr_i    (wr_ok),
    .data_i  (bus.wr_data),
    .tag_o   (wtag)
  );
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= {wtag, bus.wr_data};
  end
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      unit_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(wr_ok);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      level_q <= level_q + LW'(wr_ok) - LW'(pop);
      unit_q <= unit_q + LW'(wr_ok && wtag.eop) - LW'(pop && htag.eop);
      ovf_q <= ovf_q || (bus.wr_en && full);
    end
  end
  // Empty head reads as zero so reset/flush present all-zero data and tags.
  assign bus.rd_valid = !empty;
  assign bus.rd_data = empty ? '0 : head[31:0];
  assign bus.rd_sop = !empty && htag.sop;
  assign bus.rd_eop = !empty && htag.eop;
  assign bus.rd_term = !empty && htag.term;
  assign bus.cmd_avail = unit_q != '0;
  assign bus.level = level_q;
  assign bus.full = full;
  assign bus.empty = empty;
  assign bus.overflow = ovf_q;
  assign bus.rdy_cmd = empty;
  assign bus.rdy_dma = !full;
endmodule

// File: tb/tb_gp0_cmd_fifo.sv
// tb_gp0_cmd_fifo: table-driven tag checks plus directed burst/full/flush sequences for gp0_cmd_fifo.
module tb_gp0_cmd_fifo;
  typedef struct {
    logic [31:0] d;
    logic [2:0]  tag;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  vec_t vecs[$];
  gp0_cmd_fifo_if #(.DEPTH(16)) bus ();
  gp0_cmd_fifo #(.DEPTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic add(input logic [31:0] d, input logic [2:0] tag);
    vec_t v;
    v.d = d;
    v.tag = tag;
    vecs.push_back(v);
  endtask
  task automatic drive(input logic we, input logic [31:0] d, input logic rr);
    bus.wr_en = we;
    bus.wr_data = d;
    bus.rd_ready = rr;
    step();
    bus.wr_en = 1'b0;
    bus.rd_ready = 1'b0;
  endtask
  function automatic logic [2:0] tags();
    return {bus.rd_sop, bus.rd_eop, bus.rd_term};
  endfunction
  initial begin
    // polygon 0x20: 4 words
    add(32'h2000_00FF, 3'b100); add(32'h0000_0001, 3'b000); add(32'h0000_0002, 3'b000); add(32'h0000_0003, 3'b010);
    // 0x3C: 12 words, then single-word E1
    add(32'h3C00_0000, 3'b100);
    for (int i = 0; i < 10; i++) add(32'h0001_0000 + i, 3'b000);
    add(32'h0001_00FF, 3'b010);
    add(32'hE100_0000, 3'b110);
    // flat polyline, terminator, then 0x02 fill
    add(32'h4800_0000, 3'b100); add(32'h0000_0010, 3'b000); add(32'h0000_0011, 3'b010);
    add(32'h0000_0012, 3'b010); add(32'h5555_5555, 3'b011);
    add(32'h0200_0000, 3'b100); add(32'h0000_0000, 3'b000); add(32'h0001_0001, 3'b010);
    // image W=3 H=2 -> 3 payload words, then rect 0x60
    add(32'hA000_0000, 3'b100); add(32'h0000_0000, 3'b000); add(32'h0002_0003, 3'b010);
    add(32'h1111_1111, 3'b010); add(32'h2222_2222, 3'b010); add(32'h5000_5000, 3'b010);
    add(32'h6000_0000, 3'b100); add(32'h0000_0005, 3'b000); add(32'h0000_0006, 3'b010);
    // gouraud polyline: 2 words per group
    add(32'h5800_0000, 3'b100); add(32'h0000_0020, 3'b000); add(32'h0000_0021, 3'b000);
    add(32'h0000_0022, 3'b000); add(32'h0000_0023, 3'b010); add(32'h0000_0024, 3'b000);
    add(32'h5000_5000, 3'b010); add(32'h5555_5555, 3'b011);
    // gouraud line 0x50: 4 words
    add(32'h5000_0000, 3'b100); add(32'h0000_0030, 3'b000); add(32'h0000_0031, 3'b000); add(32'h0000_0032, 3'b010);
    // image W=1 H=1 -> 1 payload word, then opcode 0x01 single word
    add(32'hA000_0000, 3'b100); add(32'h0000_0000, 3'b000); add(32'h0001_0001, 3'b010);
    add(32'h7777_7777, 3'b010); add(32'h0100_0000, 3'b110);
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.flush = 1'b0;
    bus.rd_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_rd_data", 64'(bus.rd_data), 64'd0);
    chk("rst_tags", 64'(tags()), 64'd0);
    chk("rst_flags", 64'({bus.cmd_avail, bus.empty, bus.full, bus.overflow, bus.rdy_cmd, bus.rdy_dma}), 64'b010011);
    chk("rst_level", 64'(bus.level), 64'd0);
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].d, 1'b0);
      chk($sformatf("vec%0d_data", i), 64'(bus.rd_data), 64'(vecs[i].d));
      chk($sformatf("vec%0d_tag", i), 64'(tags()), 64'(vecs[i].tag));
      chk($sformatf("vec%0d_cmd_avail", i), 64'(bus.cmd_avail), 64'(vecs[i].tag[1]));
      drive(1'b0, '0, 1'b1);
      chk($sformatf("vec%0d_popped", i), 64'({bus.level, bus.empty}), 64'b000001);
    end
    drive(1'b1, 32'h2000_00FF, 1'b0);
    drive(1'b1, 32'h0000_0001, 1'b0);
    drive(1'b1, 32'h0000_0002, 1'b0);
    chk("burst_no_unit", 64'(bus.cmd_avail), 64'd0);
    drive(1'b1, 32'h0000_0003, 1'b0);
    chk("burst_unit", 64'(bus.cmd_avail), 64'd1);
    chk("burst_level", 64'(bus.level), 64'd4);
    drive(1'b1, 32'hE100_0000, 1'b1);
    chk("wr_pop_level", 64'(bus.level), 64'd4);
    chk("wr_pop_head", 64'(bus.rd_data), 64'd1);
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1);
    chk("drain", 64'({bus.level, bus.empty, bus.cmd_avail}), 64'b0000010);
    for (int i = 0; i < 16; i++) drive(1'b1, 32'hE100_0000 | i, 1'b0);
    chk("full_flags", 64'({bus.full, bus.rdy_dma, bus.rdy_cmd, bus.overflow}), 64'b1000);
    chk("full_level", 64'(bus.level), 64'd16);
    drive(1'b1, 32'hDEAD_BEEF, 1'b1);
    chk("ovf_set", 64'(bus.overflow), 64'd1);
    chk("ovf_level", 64'(bus.level), 64'd15);
    chk("ovf_head", 64'(bus.rd_data), 64'hE100_0001);
    drive(1'b0, '0, 1'b1);
    chk("ovf_sticky", 64'(bus.overflow), 64'd1);
    chk("ovf_head2", 64'(bus.rd_data), 64'hE100_0002);
    drive(1'b1, 32'h8000_0000, 1'b0);
    drive(1'b1, 32'h0000_0001, 1'b0);
    chk("refill_level", 64'(bus.level), 64'd16);
    bus.flush = 1'b1;
    drive(1'b1, 32'h0000_0002, 1'b0);
    bus.flush = 1'b0;
    chk("flush_level", 64'(bus.level), 64'd0);
    chk("flush_flags", 64'({bus.empty, bus.cmd_avail, bus.overflow, bus.rd_valid}), 64'b1000);
    drive(1'b1, 32'h0000_0000, 1'b0);
    chk("post_flush_tag", 64'(tags()), 64'b110);
    chk("post_flush_level", 64'({bus.level, bus.rd_valid, bus.cmd_avail}), 64'b0000111);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
